// File: rtl/ac_motor_sequencer.sv
// AC motor start/stop sequencer: precharge, power ramping, fault latch.
// Optional watchdog enabled with `define AC_MOTOR_SEQ_WATCHDOG_EN.
module ac_motor_sequencer #(
    parameter int PRECHARGE_CYCLES = 50000,
    parameter int RAMP_DIV         = 1024,
    parameter int STEP             = 1,
    parameter int WDT_CYCLES       = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] power_target,
    input  logic        fault_in,
    input  logic        fault_clr,
    input  logic        kick,
    output logic [11:0] power,
    output logic        enable,
    output logic        precharge,
    output logic [2:0]  state,
    output logic        fault,
    output logic        ready
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        RAMP      = 3'd2,
        RUN       = 3'd3,
        STOP      = 3'd4,
        FAULT     = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [19:0] pc_q, pc_d;
    logic [11:0] power_q, power_d;
    logic        enable_q, enable_d;
    logic        prech_q, prech_d;
    logic        fault_q, fault_d;
    logic        ready_q, ready_d;

    logic        active;
    logic        tick;
    logic        wdt_trip;
    logic [12:0] up13, dn13, tgt13;
    logic [11:0] ramp_val, stop_val, pow_nxt;

    assign active = (state_q == RAMP) || (state_q == RUN) ||
                    (state_q == STOP);
    assign tick   = ((state_q == RAMP) || (state_q == STOP)) &&
                    (presc_q == 16'(RAMP_DIV - 1));

`ifdef AC_MOTOR_SEQ_WATCHDOG_EN
    logic [31:0] wdt_q, wdt_d;

    // Watchdog counts while driving the motor; a kick or a passive state clears it
    always_comb begin
        wdt_d    = '0;
        wdt_trip = 1'b0;
        if (active && !kick) begin
            wdt_d    = wdt_q + 32'd1;
            wdt_trip = (wdt_q == 32'(WDT_CYCLES - 1));
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdt_q <= '0;
        else        wdt_q <= wdt_d;
    end
`else
    logic unused_wdog;
    assign unused_wdog = kick ^ (WDT_CYCLES == 0);
    assign wdt_trip    = 1'b0;
`endif

    // Power step toward the target (or toward 0 when stopping), 13-bit safe
    always_comb begin
        up13     = {1'b0, power_q} + 13'(STEP);
        dn13     = {1'b0, power_q} - 13'(STEP);
        tgt13    = {1'b0, power_target};
        ramp_val = power_q;
        if (tgt13 > {1'b0, power_q}) begin
            ramp_val = (up13 > tgt13) ? power_target : up13[11:0];
        end else if (tgt13 < {1'b0, power_q}) begin
            ramp_val = (dn13[12] || dn13 < tgt13) ? power_target : dn13[11:0];
        end
        stop_val = dn13[12] ? 12'd0 : dn13[11:0];
        pow_nxt  = power_q;
        if (tick) pow_nxt = (state_q == STOP) ? stop_val : ramp_val;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic; faults override every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = PRECHARGE;
            end
            PRECHARGE: begin
                if (!start)                                state_d = IDLE;
                else if (pc_q == 20'(PRECHARGE_CYCLES - 1)) state_d = RAMP;
            end
            RAMP: begin
                if (!start)                       state_d = STOP;
                else if (pow_nxt == power_target) state_d = RUN;
            end
            RUN: begin
                if (!start)                       state_d = STOP;
                else if (power_target != power_q) state_d = RAMP;
            end
            STOP: begin
                if (start)              state_d = RAMP;
                else if (power_q == '0) state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr && !fault_in && !start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fault_in || wdt_trip) state_d = FAULT;

        presc_d = '0;
        if (state_d == state_q && !tick &&
            (state_q == RAMP || state_q == STOP)) begin
            presc_d = presc_q + 16'd1;
        end

        pc_d = '0;
        if (state_q == PRECHARGE && state_d == PRECHARGE) begin
            pc_d = pc_q + 20'd1;
        end
    end

    // Output next values, derived from the state being entered
    always_comb begin
        power_d   = power_q;
        enable_d  = 1'b0;
        prech_d   = 1'b0;
        fault_d   = (state_d == FAULT);
        ready_d   = (state_d == RUN);
        unique case (state_d)
            IDLE, PRECHARGE, FAULT: begin
                power_d = '0;
                prech_d = (state_d == PRECHARGE);
            end
            default: begin
                enable_d = 1'b1;
                prech_d  = 1'b1;
                if (state_d == state_q || (state_q == RAMP && state_d == RUN)) begin
                    power_d = pow_nxt;
                end
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_q  <= '0;
            enable_q <= 1'b0;
            prech_q  <= 1'b0;
            fault_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            power_q  <= power_d;
            enable_q <= enable_d;
            prech_q  <= prech_d;
            fault_q  <= fault_d;
            ready_q  <= ready_d;
        end
    end

    assign power     = power_q;
    assign enable    = enable_q;
    assign precharge = prech_q;
    assign state     = state_q;
    assign fault     = fault_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_ac_motor_sequencer.sv
// Bench for ac_motor_sequencer: directed sequences plus random retargets
// checked against an arithmetic ramp model.
module tb_ac_motor_sequencer;

    localparam int PCY  = 10;
    localparam int RDIV = 4;
    localparam int STP  = 16;
    localparam int WDT  = 20;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_RAMP = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] power_target;
    logic        fault_in;
    logic        fault_clr;
    logic        kick;
    logic [11:0] power;
    logic        enable;
    logic        precharge;
    logic [2:0]  state;
    logic        fault;
    logic        ready;

    int n_pass  = 0;
    int n_total = 0;
    int exp_p   = 0;
    int cyc     = 0;
    int kick_per = 1;

    ac_motor_sequencer #(
        .PRECHARGE_CYCLES(PCY),
        .RAMP_DIV(RDIV),
        .STEP(STP),
        .WDT_CYCLES(WDT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .power_target(power_target),
        .fault_in(fault_in),
        .fault_clr(fault_clr),
        .kick(kick),
        .power(power),
        .enable(enable),
        .precharge(precharge),
        .state(state),
        .fault(fault),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        kick = (kick_per != 0) && ((cyc % kick_per) == 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Walk a ramp step by step, predicting each value arithmetically
    task automatic run_ramp(input int tgt, input bit stopping, input string tag);
        int p, nxt, goal;
        logic [2:0] es;
        p    = exp_p;
        goal = stopping ? 0 : tgt;
        while (p != goal) begin
            if (stopping)     nxt = (p > STP) ? p - STP : 0;
            else if (tgt > p) nxt = (p + STP > tgt) ? tgt : p + STP;
            else              nxt = (p - STP < tgt) ? tgt : p - STP;
            repeat (RDIV - 1) tick();
            n_total++;
            if (power !== 12'(p))
                $display("FAIL %s_hold power=%0d want %0d", tag, power, p);
            else n_pass++;
            tick();
            n_total++;
            if (power !== 12'(nxt))
                $display("FAIL %s_step power=%0d want %0d", tag, power, nxt);
            else n_pass++;
            p  = nxt;
            es = stopping ? S_STOP : ((p == goal) ? S_RUN : S_RAMP);
            n_total++;
            if (state !== es)
                $display("FAIL %s_state state=%0d want %0d", tag, state, es);
            else n_pass++;
        end
        exp_p = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({state, power, enable, precharge, fault, ready} !== '0)
            $display("FAIL reset_outs state=%0d power=%0d en=%b pc=%b want 0",
                     state, power, enable, precharge);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (state !== S_IDLE) $display("FAIL reset_idle state=%0d want 0", state);
        else n_pass++;
        tick();
        n_total++;
        if (state !== S_PRE) $display("FAIL reset_pre state=%0d want 1", state);
        else n_pass++;
        start = 1'b0;
        tick();
        exp_p = 0;
    endtask

    task automatic test_powerup(input int tgt);
        int n_pre;
        n_pre = 0;
        power_target = 12'(tgt);
        start = 1'b1;
        tick();
        for (int i = 0; i < 50 && enable !== 1'b1; i++) begin
            if (precharge === 1'b1 && state === S_PRE) n_pre++;
            tick();
        end
        n_total++;
        if (n_pre != PCY) $display("FAIL pre_cycles got=%0d want %0d", n_pre, PCY);
        else n_pass++;
        n_total++;
        if ({state, power, enable, precharge} !== {S_RAMP, 12'd0, 1'b1, 1'b1})
            $display("FAIL ramp_entry state=%0d power=%0d en=%b want 2/0/1",
                     state, power, enable);
        else n_pass++;
        exp_p = 0;
        run_ramp(tgt, 1'b0, "up");
        n_total++;
        if (ready !== 1'b1) $display("FAIL up_ready ready=%b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_retarget(input int tgt);
        power_target = 12'(tgt);
        tick();
        n_total++;
        if (state !== S_RAMP || power !== 12'(exp_p))
            $display("FAIL retgt_entry state=%0d power=%0d want 2/%0d",
                     state, power, exp_p);
        else n_pass++;
        run_ramp(tgt, 1'b0, "retgt");
        n_total++;
        if (ready !== 1'b1 || power !== 12'(tgt))
            $display("FAIL retgt_done ready=%b power=%0d want 1/%0d",
                     ready, power, tgt);
        else n_pass++;
    endtask

    task automatic test_stop();
        start = 1'b0;
        tick();
        n_total++;
        if (state !== S_STOP || enable !== 1'b1 || power !== 12'(exp_p))
            $display("FAIL stop_entry state=%0d en=%b power=%0d want 4/1/%0d",
                     state, enable, power, exp_p);
        else n_pass++;
        run_ramp(0, 1'b1, "stop");
        tick();
        n_total++;
        if ({state, power, enable, precharge} !== {S_IDLE, 12'd0, 1'b0, 1'b0})
            $display("FAIL stop_idle state=%0d power=%0d en=%b pc=%b want 0",
                     state, power, enable, precharge);
        else n_pass++;
    endtask

    task automatic test_fault();
        power_target = 12'd64;
        start = 1'b1;
        for (int i = 0; i < 50 && state !== S_RAMP; i++) tick();
        repeat (6) tick();
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        n_total++;
        if ({state, power, enable, precharge, fault, ready} !==
            {S_FLT, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0})
            $display("FAIL fault_entry state=%0d power=%0d en=%b f=%b want 5/0/0/1",
                     state, power, enable, fault);
        else n_pass++;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick();
        n_total++;
        if (state !== S_FLT) $display("FAIL clr_start state=%0d want 5", state);
        else n_pass++;
        start = 1'b0;
        fault_in = 1'b1;
        tick();
        n_total++;
        if (state !== S_FLT) $display("FAIL clr_fin state=%0d want 5", state);
        else n_pass++;
        fault_in = 1'b0;
        tick();
        fault_clr = 1'b0;
        n_total++;
        if (state !== S_IDLE || fault !== 1'b0)
            $display("FAIL clr_ok state=%0d fault=%b want 0/0", state, fault);
        else n_pass++;
        exp_p = 0;
    endtask

    task automatic test_reset_async();
        test_powerup(100);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({state, power, enable, precharge, fault, ready} !== '0)
            $display("FAIL async_rst state=%0d power=%0d en=%b want 0",
                     state, power, enable);
        else n_pass++;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_p = 0;
    endtask

    task automatic test_precharge_abort();
        bit en_seen;
        en_seen = 1'b0;
        start = 1'b1;
        tick();
        repeat (5) begin
            if (enable === 1'b1) en_seen = 1'b1;
            tick();
        end
        start = 1'b0;
        tick();
        n_total++;
        if (state !== S_IDLE || en_seen || precharge !== 1'b0)
            $display("FAIL pre_abort state=%0d en_seen=%b pc=%b want 0/0/0",
                     state, en_seen, precharge);
        else n_pass++;
    endtask

    task automatic test_random();
        int t;
        test_powerup($urandom_range(1, 4095));
        test_retarget(4095);
        test_retarget(0);
        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(0, 4095);
            if (t == exp_p) t = t ^ 1;
            test_retarget(t);
        end
        test_stop();
    endtask

`ifdef AC_MOTOR_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        kick_per = 1;
        test_powerup(16);
        kick_per = 0;
        n = 0;
        while (state !== S_FLT && n < 100) begin
            tick();
            n++;
        end
        n_total++;
        if (n != WDT) $display("FAIL wdt_trip cycles=%0d want %0d", n, WDT);
        else n_pass++;
        start = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        kick_per = 10;
        test_powerup(16);
        repeat (100) tick();
        n_total++;
        if (state !== S_RUN) $display("FAIL wdt_kicked state=%0d want 3", state);
        else n_pass++;
        kick_per = 1;
        test_stop();
    endtask
`else
    task automatic test_kick_ignored();
        test_powerup(32);
        kick_per = 0;
        repeat (60) tick();
        n_total++;
        if (state !== S_RUN) $display("FAIL nokick state=%0d want 3", state);
        else n_pass++;
        kick_per = 3;
        repeat (30) tick();
        n_total++;
        if (state !== S_RUN || ready !== 1'b1)
            $display("FAIL kick_pulses state=%0d ready=%b want 3/1", state, ready);
        else n_pass++;
        kick_per = 1;
        test_stop();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        power_target = '0;
        fault_in = 1'b0;
        fault_clr = 1'b0;
        kick = 1'b0;
        test_reset();
        test_powerup(64);
        test_retarget(40);
        test_stop();
        test_fault();
        test_reset_async();
        test_precharge_abort();
        test_random();
`ifdef AC_MOTOR_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_kick_ignored();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ac_motor_sequencer.md
AC_MOTOR_SEQUENCER -- requirements
Module: ac_motor_sequencer

Interface
REQ-001 SHALL have parameter: PRECHARGE_CYCLES, 50000, clocks spent in PRECHARGE (1..2^20-1).
REQ-002 SHALL have parameter: RAMP_DIV, 1024, clocks per ramp step (1..65535).
REQ-003 SHALL have parameter: STEP, 1, power increment per ramp step (1..4095).
REQ-004 SHALL have parameter: WDT_CYCLES, 65535, watchdog timeout in clocks (used only with AC_MOTOR_SEQ_WATCHDOG_EN).
REQ-005 SHALL have the following ports, clock and reset first:
- clk  input  1  system clock; one clock domain, all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  run request, level; 1 = run, 0 = stop.
- power_target  input  12  requested power for AC_MOTOR_CONTROL.
- fault_in  input  1  synchronous fault, active-high (overcurrent/overvoltage).
- fault_clr  input  1  fault acknowledge, single-cycle pulse.
- kick  input  1  watchdog heartbeat, single-cycle pulse.
- power  output  12  ramped power, to AC_MOTOR_CONTROL.
- enable  output  1  gate enable, to all AC_MOTOR_SWITCH_DELAY instances.
- precharge  output  1  DC-link precharge relay drive.
- state  output  3  current state encoding.
- fault  output  1  1 while in FAULT.
- ready  output  1  1 while in RUN.

Function
REQ-006 SHALL use state encoding IDLE=0, PRECHARGE=1, RAMP=2, RUN=3, STOP=4, FAULT=5; all outputs SHALL be registered.
REQ-007 IDLE: power=0, enable=0, precharge=0; start=1 SHALL enter PRECHARGE next cycle.
REQ-008 PRECHARGE: precharge=1, enable=0, power=0; after exactly PRECHARGE_CYCLES clocks in the state SHALL enter RAMP; start=0 SHALL return to IDLE next cycle.
REQ-009 RAMP: enable=1, precharge=1; on every RAMP_DIV-th clock in RAMP/STOP, power SHALL move STEP toward power_target, clamped to never overshoot it.
REQ-010 RAMP SHALL enter RUN on the cycle power equals power_target; power_target=0 while in RAMP SHALL ramp down to 0 and then enter RUN with power=0.
REQ-011 RUN: power SHALL hold; a change of power_target SHALL re-enter RAMP next cycle; the prescaler SHALL restart at 0 on every entry to RAMP or STOP.
REQ-012 start=0 in RAMP or RUN SHALL enter STOP; STOP SHALL ramp power down by STEP per RAMP_DIV clocks, saturating at 0, enable=1.
REQ-013 STOP SHALL enter IDLE on the cycle after power reaches 0; start=1 during STOP SHALL re-enter RAMP.
REQ-014 fault_in=1 in any state SHALL enter FAULT next cycle, overriding all other transitions; FAULT forces power=0, enable=0, precharge=0 on that same cycle.
REQ-015 FAULT SHALL exit to IDLE only on fault_clr=1 with fault_in=0 and start=0 in the same cycle; fault_clr under any other condition SHALL be ignored.
REQ-016 Power arithmetic SHALL use 13-bit intermediate results, so up-ramps saturate at 4095 and down-ramps at 0, with no wrap-around.

Reset
REQ-017 rst_n=0 SHALL immediately force state=IDLE, power=0, enable=0, precharge=0, fault=0, ready=0, and clear all counters, regardless of clk.
REQ-018 Reset deasserted while start=1 SHALL take one cycle in IDLE before entering PRECHARGE.

Configuration
REQ-019 With AC_MOTOR_SEQ_WATCHDOG_EN defined:
- A watchdog counter SHALL clear on kick and in IDLE/PRECHARGE/FAULT.
- The counter SHALL increment in RAMP/RUN/STOP.
- Reaching WDT_CYCLES SHALL enter FAULT, exactly as for fault_in.
REQ-020 Without AC_MOTOR_SEQ_WATCHDOG_EN, the kick port SHALL exist but be ignored, and no watchdog logic SHALL be synthesized.

Verification (bench parameters PRECHARGE_CYCLES=10, RAMP_DIV=4, STEP=16)
REQ-021 Power-up: start=1, power_target=64 -> 10 cycles precharge=1, then enable=1; power steps 16/32/48/64 every 4 clocks; ready=1 at power=64.
REQ-022 Retarget: in RUN at 64, power_target=40 -> RAMP, power 48 then 40 (clamped, no overshoot), then RUN.
REQ-023 Stop: start=0 at power=40 -> power 24/8/0 every 4 clocks; IDLE the following cycle; enable=0, precharge=0.
REQ-024 Fault: fault_in pulse mid-RAMP -> next cycle power=0, enable=0, fault=1; fault_clr with start=1 ignored; fault_clr with start=0 -> IDLE.
REQ-025 Reset: rst_n low mid-RUN -> outputs zero asynchronously, before the next clk edge; start=0 during PRECHARGE -> IDLE with enable never asserted.
REQ-026 Watchdog: AC_MOTOR_SEQ_WATCHDOG_EN defined, WDT_CYCLES=20, no kick in RUN -> FAULT after 20 cycles; a kick every 10 cycles -> remains in RUN.
